// File: rtl/int_ctrl_if.sv
// Wishbone slave bundle between the intercon and the interrupt controller.
// The intercon drives the master side; int_ctrl is the slave.
interface int_ctrl_if;
    logic        STB;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;

    modport master (output STB, WE, ADDR, DAT_I, input DAT_O, ACK);
    modport slave  (input STB, WE, ADDR, DAT_I, output DAT_O, ACK);
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises raw source levels, latches rising edges into a
// W1C pending register, masks them, and drives a registered INT plus priority CAUSE.
module int_ctrl #(
    parameter int unsigned N_SRC   = 6,
    parameter int unsigned CAUSE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   irq,
    int_ctrl_if.slave          bus,
    output logic               INT,
    output logic [CAUSE_W-1:0] CAUSE
);
    logic [N_SRC-1:0]   s1, s2, s3;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   pending, pending_next;
    logic [N_SRC-1:0]   mask, mask_next;
    logic [N_SRC-1:0]   active;
    logic [N_SRC-1:0]   clr;
    logic [CAUSE_W-1:0] cause_next;
    logic               found;
    logic [31:0]        rd_data;
    logic               access;
    logic               wr;
    logic [1:0]         reg_sel;
    logic               unused_bits;

    assign reg_sel     = bus.ADDR[3:2];
    assign access      = bus.STB & ~bus.ACK;
    assign wr          = access & bus.WE;
    assign rise        = s2 & ~s3;
    assign active      = pending & mask;
    assign unused_bits = ^{bus.ADDR[31:4], bus.ADDR[1:0], bus.DAT_I};

    // A fresh rise is OR-ed in after the clear so it survives a same-cycle W1C.
    always_comb begin
        clr       = '0;
        mask_next = mask;
        if (wr && reg_sel == 2'd0)
            clr = bus.DAT_I[N_SRC-1:0];
        if (wr && reg_sel == 2'd1)
            mask_next = bus.DAT_I[N_SRC-1:0];
        pending_next = (pending & ~clr) | rise;
    end

    always_comb begin
        cause_next = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (active[i] && !found) begin
                cause_next = CAUSE_W'(i);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0:    rd_data[N_SRC-1:0] = pending;
            2'd1:    rd_data[N_SRC-1:0] = mask;
            2'd2:    rd_data[N_SRC-1:0] = s2;
            default: rd_data = 32'(CAUSE);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            pending   <= '0;
            mask      <= '0;
            INT       <= 1'b0;
            CAUSE     <= '0;
            bus.ACK   <= 1'b0;
            bus.DAT_O <= '0;
        end else begin
            s1      <= irq;
            s2      <= s1;
            s3      <= s2;
            pending <= pending_next;
            mask    <= mask_next;
            INT     <= |active;
            CAUSE   <= cause_next;
            bus.ACK <= bus.STB & ~bus.ACK;
            if (access)
                bus.DAT_O <= rd_data;
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: bus reads queue their expected data, a monitor
// pops on every ACK; INT/CAUSE are compared against a set-based pending/mask model.
module tb_int_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  irq = '0;
    logic        INT;
    logic [31:0] CAUSE;

    int_ctrl_if bus ();

    int_ctrl #(.N_SRC(6), .CAUSE_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .irq   (irq),
        .bus   (bus),
        .INT   (INT),
        .CAUSE (CAUSE)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] exp_q[$];
    bit          rd_q[$];
    string       nm_q[$];

    // Reference model: which sources have an unacknowledged edge, and which are enabled.
    logic [5:0] pend_m = '0;
    logic [5:0] mask_m = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cause(input logic [5:0] v);
        for (int i = 0; i < 6; i++)
            if (v[i]) return 32'(i);
        return 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string nm);
        chk({nm, "_int"}, 32'(INT), 32'(|(pend_m & mask_m)));
        chk({nm, "_cause"}, CAUSE, exp_cause(pend_m & mask_m));
    endtask

    // Issued at posedge+1; ACK is expected one edge later, then the strobe is dropped.
    task automatic access(input logic we, input logic [1:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string nm);
        logic [31:0] junk;
        junk = $urandom();
        exp_q.push_back(exp);
        rd_q.push_back(!we);
        nm_q.push_back(nm);
        bus.STB   = 1'b1;
        bus.WE    = we;
        bus.ADDR  = {junk[31:4], a, junk[1:0]};
        bus.DAT_I = d;
        tick();
        chk({nm, "_ack"}, 32'(bus.ACK), 32'd1);
        bus.STB = 1'b0;
        bus.WE  = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [5:0] bits);
        irq = bits;
        tick();
        irq = '0;
        repeat (4) tick();
        pend_m = pend_m | bits;
    endtask

    always @(negedge clk) begin
        if (bus.ACK === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("spurious_ack", 32'(bus.ACK), 32'd0);
            end else begin
                automatic logic [31:0] e  = exp_q.pop_front();
                automatic bit          r  = rd_q.pop_front();
                automatic string       nm = nm_q.pop_front();
                if (r) chk(nm, bus.DAT_O, e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  a;
        bus.STB = 1'b0; bus.WE = 1'b0; bus.ADDR = '0; bus.DAT_I = '0;
        #2;
        chk("rst_int", 32'(INT), 32'd0);
        chk("rst_cause", CAUSE, 32'd0);
        chk("rst_ack", 32'(bus.ACK), 32'd0);
        chk("rst_dato", bus.DAT_O, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();

        // idle after reset
        status("idle");
        access(1'b0, 2'd0, '0, 32'h0, "idle_pending");
        access(1'b0, 2'd1, '0, 32'h0, "idle_mask");
        access(1'b0, 2'd2, '0, 32'h0, "idle_raw");
        access(1'b0, 2'd3, '0, 32'h0, "idle_cause");

        // exact latency of a single one-cycle pulse on source 3
        access(1'b1, 2'd1, 32'h3F, '0, "wr_mask");
        mask_m = 6'h3F;
        irq = 6'h08;
        tick();
        irq = '0;
        tick();
        chk("lat_int_early", 32'(INT), 32'd0);
        access(1'b0, 2'd0, '0, 32'h0, "lat_pending_early");
        pend_m = 6'h08;
        status("lat_k3");
        access(1'b0, 2'd0, '0, 32'h08, "lat_pending");
        access(1'b1, 2'd0, 32'h08, '0, "clr3");
        pend_m = '0;
        status("clr3");

        // priority between simultaneous sources 1 and 3
        pulse(6'h0A);
        status("prio_both");
        access(1'b1, 2'd0, 32'h02, '0, "clr1");
        pend_m = pend_m & ~6'h02;
        status("prio_after_clr1");
        access(1'b1, 2'd0, 32'h08, '0, "clr3b");
        pend_m = pend_m & ~6'h08;
        status("prio_after_clr3");

        // masked source latches, unmask raises INT one edge after commit
        access(1'b1, 2'd1, 32'h00, '0, "mask_off");
        mask_m = '0;
        pulse(6'h10);
        access(1'b0, 2'd0, '0, 32'h10, "masked_pending");
        status("masked");
        access(1'b1, 2'd1, 32'h10, '0, "unmask4");
        mask_m = 6'h10;
        status("unmask4");
        access(1'b1, 2'd0, 32'h10, '0, "clr4");
        pend_m = '0;

        // held level: W1C coinciding with the rise keeps the bit, later clear sticks
        access(1'b1, 2'd1, 32'h3F, '0, "mask_all");
        mask_m = 6'h3F;
        irq = 6'h08;
        tick();
        tick();
        access(1'b1, 2'd0, 32'h08, '0, "clr_vs_rise");
        pend_m = 6'h08;
        status("set_wins");
        access(1'b0, 2'd0, '0, 32'h08, "set_wins_pending");
        access(1'b1, 2'd0, 32'h08, '0, "clr_level");
        pend_m = '0;
        repeat (3) tick();
        access(1'b0, 2'd0, '0, 32'h0, "level_no_reset");
        access(1'b0, 2'd2, '0, 32'h08, "raw_level");
        status("level_cleared");
        irq = '0;
        repeat (4) tick();

        // randomized operations against the model
        for (int n = 0; n < 80; n++) begin
            d = $urandom();
            a = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: pulse(6'($urandom_range(1, 63)));
                1: begin
                    access(1'b1, 2'd1, d, '0, "rnd_mask");
                    mask_m = d[5:0];
                end
                2: begin
                    access(1'b1, 2'd0, d, '0, "rnd_w1c");
                    pend_m = pend_m & ~d[5:0];
                end
                3: access(1'b1, 2'($urandom_range(2, 3)), d, '0, "rnd_ro_write");
                default: begin
                    case (a)
                        2'd0: access(1'b0, a, d, {26'd0, pend_m}, "rnd_rd_pending");
                        2'd1: access(1'b0, a, d, {26'd0, mask_m}, "rnd_rd_mask");
                        2'd2: access(1'b0, a, d, 32'h0, "rnd_rd_raw");
                        default: access(1'b0, a, d, exp_cause(pend_m & mask_m), "rnd_rd_cause");
                    endcase
                end
            endcase
            status("rnd");
        end

        // reset in the middle of a held MASK write
        access(1'b1, 2'd0, 32'h3F, '0, "pre_rst_clr");
        pend_m = '0;
        bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = 32'h4; bus.DAT_I = 32'h3F;
        tick();
        #1 rst = 1'b1;
        #1;
        chk("midrst_ack", 32'(bus.ACK), 32'd0);
        chk("midrst_int", 32'(INT), 32'd0);
        tick();
        bus.STB = 1'b0; bus.WE = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();
        mask_m = '0;
        pend_m = '0;
        access(1'b0, 2'd1, '0, 32'h0, "midrst_mask");
        access(1'b1, 2'd1, 32'h3F, '0, "post_rst_wr");
        mask_m = 6'h3F;
        access(1'b0, 2'd1, '0, 32'h3F, "post_rst_mask");
        pulse(6'h20);
        status("post_rst");

        tick();
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
